pickups_ctl: RTL and testbench

- Parametrised pickup manager for the Binary Land playfield.
- Holds N_PICKUPS collectible items at fixed positions and draws the alive ones into the VGA pixel stream.
- Once per frame, during vertical blank, checks the hero's bounding box against every alive pickup; clears each one touched and counts it in a score.
- Sits in the draw chain after the background/hero stage: takes the vga_timing-style stream in, outputs it delayed by one cycle.

---
 rtl/pickups_ctl.sv | 215 +++++++++++++++++++++
 tb/tb_pickups_ctl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pickups_ctl.sv
// Pickup manager: draws alive pickups into the pixel stream (1 pclk latency) and scans
// hero overlap once per frame in vblank. Optional respawn timers under PICKUP_RESPAWN_EN.
module pickups_ctl #(
    parameter int                       N_PICKUPS      = 5,
    parameter logic [24*N_PICKUPS-1:0]  PICKUP_POS     = '0,
    parameter int                       PICKUP_W       = 16,
    parameter int                       PICKUP_H       = 16,
    parameter int                       HERO_W         = 32,
    parameter int                       HERO_H         = 32,
    parameter logic [11:0]              PICKUP_RGB     = 12'hFF0,
    parameter int                       SCORE_W        = 8,
    parameter int                       RESPAWN_FRAMES = 600
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic [10:0]           hcount_in,
    input  logic [10:0]           vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [11:0]           rgb_in,
    input  logic [11:0]           x_pos_hero,
    input  logic [11:0]           y_pos_hero,
    input  logic                  restart,
    output logic [10:0]           hcount_out,
    output logic [10:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [11:0]           rgb_out,
    output logic [N_PICKUPS-1:0]  alive,
    output logic [SCORE_W-1:0]    score,
    output logic                  collect,
    output logic                  all_collected
);
    localparam int IDX_W = (N_PICKUPS > 1) ? $clog2(N_PICKUPS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [11:0]          hx_q, hx_d, hy_q, hy_d;
    logic [N_PICKUPS-1:0] alive_q, alive_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 collect_q, collect_d;
    logic                 allc_q, allc_d;
    logic                 tick_q;
    logic [10:0]          hcount_q, vcount_q;
    logic                 hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0]          rgb_q, rgb_d;

`ifdef PICKUP_RESPAWN_EN
    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 2);
    logic [CNT_W-1:0] cnt_q [N_PICKUPS];
    logic [CNT_W-1:0] cnt_d [N_PICKUPS];
`endif

    // Pixel compositing, 13-bit compares so x+W never wraps.
    always_comb begin
        logic [12:0] h13, v13, px, py;
        logic        on_pickup;
        h13       = {2'b00, hcount_in};
        v13       = {2'b00, vcount_in};
        px        = '0;
        py        = '0;
        on_pickup = 1'b0;
        for (int i = 0; i < N_PICKUPS; i++) begin
            px = {1'b0, PICKUP_POS[24*i +: 12]};
            py = {1'b0, PICKUP_POS[24*i+12 +: 12]};
            if (alive_q[i] && h13 >= px && h13 < px + 13'(PICKUP_W) &&
                v13 >= py && v13 < py + 13'(PICKUP_H))
                on_pickup = 1'b1;
        end
        if (hblnk_in || vblnk_in) rgb_d = 12'h000;
        else if (on_pickup)       rgb_d = PICKUP_RGB;
        else                      rgb_d = rgb_in;
    end

    always_comb begin
        logic [N_PICKUPS-1:0] sel_oh;
        logic [23:0]          sel_pos;
        logic [12:0]          hx13, hy13, spx, spy;
        logic                 hit;
        state_d   = state_q;
        idx_d     = idx_q;
        hx_d      = hx_q;
        hy_d      = hy_q;
        alive_d   = alive_q;
        score_d   = score_q;
        collect_d = 1'b0;
        allc_d    = allc_q;
        sel_oh    = '0;
        sel_pos   = '0;
`ifdef PICKUP_RESPAWN_EN
        cnt_d     = cnt_q;
`endif
        for (int i = 0; i < N_PICKUPS; i++) begin
            sel_oh[i] = (idx_q == IDX_W'(i));
            if (sel_oh[i]) sel_pos = PICKUP_POS[24*i +: 24];
        end
        hx13 = {1'b0, hx_q};
        hy13 = {1'b0, hy_q};
        spx  = {1'b0, sel_pos[11:0]};
        spy  = {1'b0, sel_pos[23:12]};
        hit  = |(alive_q & sel_oh) &&
               hx13 < spx + 13'(PICKUP_W) && spx < hx13 + 13'(HERO_W) &&
               hy13 < spy + 13'(PICKUP_H) && spy < hy13 + 13'(HERO_H);

        case (state_q)
            IDLE: if (tick_q) begin
                state_d = SCAN;
                idx_d   = '0;
                hx_d    = x_pos_hero;
                hy_d    = y_pos_hero;
            end
            SCAN: begin
                if (hit) begin
                    alive_d   = alive_q & ~sel_oh;
                    collect_d = 1'b1;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
`ifdef PICKUP_RESPAWN_EN
                    // One extra count absorbs the decrement in this same frame's DONE.
                    for (int i = 0; i < N_PICKUPS; i++)
                        if (sel_oh[i]) cnt_d[i] = CNT_W'(RESPAWN_FRAMES + 1);
`endif
                end
                if (idx_q == IDX_W'(N_PICKUPS - 1)) state_d = DONE;
                else                                 idx_d   = idx_q + IDX_W'(1);
            end
            DONE: begin
                allc_d  = (alive_q == '0);
                state_d = IDLE;
`ifdef PICKUP_RESPAWN_EN
                for (int i = 0; i < N_PICKUPS; i++) begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        if (cnt_q[i] == CNT_W'(1)) alive_d[i] = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d   = IDLE;
            alive_d   = '1;
            score_d   = '0;
            allc_d    = 1'b0;
            collect_d = 1'b0;
`ifdef PICKUP_RESPAWN_EN
            for (int i = 0; i < N_PICKUPS; i++) cnt_d[i] = '0;
`endif
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q  <= '0;
            vcount_q  <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            hblnk_q   <= 1'b0;
            vblnk_q   <= 1'b0;
            rgb_q     <= '0;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            idx_q     <= '0;
            hx_q      <= '0;
            hy_q      <= '0;
            alive_q   <= '1;
            score_q   <= '0;
            collect_q <= 1'b0;
            allc_q    <= 1'b0;
`ifdef PICKUP_RESPAWN_EN
            for (int i = 0; i < N_PICKUPS; i++) cnt_q[i] <= '0;
`endif
        end else begin
            hcount_q  <= hcount_in;
            vcount_q  <= vcount_in;
            hsync_q   <= hsync_in;
            vsync_q   <= vsync_in;
            hblnk_q   <= hblnk_in;
            vblnk_q   <= vblnk_in;
            rgb_q     <= rgb_d;
            tick_q    <= vblnk_in & ~vblnk_q & ~restart;
            state_q   <= state_d;
            idx_q     <= idx_d;
            hx_q      <= hx_d;
            hy_q      <= hy_d;
            alive_q   <= alive_d;
            score_q   <= score_d;
            collect_q <= collect_d;
            allc_q    <= allc_d;
`ifdef PICKUP_RESPAWN_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign hcount_out    = hcount_q;
    assign vcount_out    = vcount_q;
    assign hsync_out     = hsync_q;
    assign vsync_out     = vsync_q;
    assign hblnk_out     = hblnk_q;
    assign vblnk_out     = vblnk_q;
    assign rgb_out       = rgb_q;
    assign alive         = alive_q;
    assign score         = score_q;
    assign collect       = collect_q;
    assign all_collected = allc_q;

endmodule

// File: tb/tb_pickups_ctl.sv
// Scoreboard bench for pickups_ctl: pixel expectations and collect-pulse timings are
// queued when stimulus is driven and compared as the DUT produces them.
module tb_pickups_ctl;
    localparam int N    = 5;
    localparam int RESP = 3;
    localparam logic [24*N-1:0] POS = {12'd400, 12'd50,  12'd300, 12'd600, 12'd110, 12'd420,
                                       12'd100, 12'd400, 12'd100, 12'd200};

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, x_pos_hero, y_pos_hero;
    logic        restart;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [N-1:0] alive;
    logic [7:0]  score;
    logic        collect, all_collected;

    pickups_ctl #(
        .N_PICKUPS(N), .PICKUP_POS(POS), .PICKUP_W(16), .PICKUP_H(16),
        .HERO_W(32), .HERO_H(32), .PICKUP_RGB(12'hFF0), .SCORE_W(8),
        .RESPAWN_FRAMES(RESP)
    ) dut (
        .pclk(pclk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .x_pos_hero(x_pos_hero), .y_pos_hero(y_pos_hero), .restart(restart),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .alive(alive), .score(score), .collect(collect),
        .all_collected(all_collected)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    int        px [N];
    int        py [N];
    logic [N-1:0] m_alive;
    int        m_score;
    logic      m_allc;
    int        m_cnt [N];
    logic [22:0] pix_q [$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int h, input int v, input int hb, input int vb,
                                              input logic [11:0] rgb);
        if (hb != 0 || vb != 0) return 12'h000;
        for (int i = 0; i < N; i++)
            if (m_alive[i] && h >= px[i] && h < px[i] + 16 && v >= py[i] && v < py[i] + 16)
                return 12'hFF0;
        return rgb;
    endfunction

    task automatic pix(input int h, input int v, input int hb, input int vb, input logic [11:0] rgb);
        logic [22:0] e;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb[0];
        vblnk_in  = vb[0];
        rgb_in    = rgb;
        pix_q.push_back({11'(h), model_rgb(h, v, hb, vb, rgb)});
        @(posedge pclk); #1;
        e = pix_q.pop_front();
        check_eq("rgb_out", int'(rgb_out), int'(e[11:0]));
        check_eq("hcount_out", int'(hcount_out), int'(e[22:12]));
    endtask

    // One vblank: rising vblnk_in, then N+3 clock edges of observation.
    // rst_at > 0 pulses restart so that it is sampled at that edge.
    task automatic frame(input int hx, input int hy, input int rst_at);
        int   ev_q [$];
        logic fresh [N];
        logic [N-1:0] a_new;
        int   s_new;
        logic ac_old, ac_new;
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
        @(posedge pclk); #1;
        x_pos_hero = 12'(hx);
        y_pos_hero = 12'(hy);
        vblnk_in   = 1'b1;

        a_new = m_alive;
        s_new = m_score;
        for (int i = 0; i < N; i++) begin
            fresh[i] = 1'b0;
            if (m_alive[i] && hx < px[i] + 16 && px[i] < hx + 32 && hy < py[i] + 16 && py[i] < hy + 32) begin
                a_new[i] = 1'b0;
                if (s_new < 255) s_new++;
                if (rst_at == 0 || i + 2 < rst_at) ev_q.push_back(i + 2);
                fresh[i] = 1'b1;
                m_cnt[i] = RESP;
            end
        end
        ac_old = m_allc;
        ac_new = (a_new == '0);
`ifdef PICKUP_RESPAWN_EN
        for (int i = 0; i < N; i++)
            if (!fresh[i] && m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) a_new[i] = 1'b1;
            end
`endif
        if (rst_at > 0) begin
            a_new  = '1;
            s_new  = 0;
            ac_new = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            if (rst_at <= N + 1) ac_old = 1'b0;
        end

        @(posedge pclk); #1;
        for (int e = 1; e <= N + 3; e++) begin
            if (e == rst_at) restart = 1'b1;
            @(posedge pclk); #1;
            restart = 1'b0;
            // Hero moves onto pickup 3 after being latched; must not matter for this scan.
            if (e == 1) begin
                x_pos_hero = 12'd610;
                y_pos_hero = 12'd310;
            end
            if (collect) begin
                if (ev_q.size() > 0) check_eq("collect_edge", e, ev_q.pop_front());
                else                 check_eq("collect_extra", 1, 0);
            end
            if (e == N + 1) check_eq("allc_before_done", int'(all_collected), int'(ac_old));
            if (e == N + 2) begin
                check_eq("all_collected", int'(all_collected), int'(ac_new));
                check_eq("alive", int'(alive), int'(a_new));
                check_eq("score", int'(score), s_new);
            end
        end
        check_eq("collect_missing", ev_q.size(), 0);
        m_alive = a_new;
        m_score = s_new;
        m_allc  = ac_new;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            px[i]    = int'(POS[24*i +: 12]);
            py[i]    = int'(POS[24*i+12 +: 12]);
            m_cnt[i] = 0;
        end
        m_alive = '1;
        m_score = 0;
        m_allc  = 1'b0;

        rst_n = 1'b0;
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'h123; x_pos_hero = '0; y_pos_hero = '0; restart = 1'b0;
        #12;
        check_eq("rst_rgb_out", int'(rgb_out), 0);
        check_eq("rst_hsync_out", int'(hsync_out), 0);
        check_eq("rst_alive", int'(alive), 31);
        check_eq("rst_score", int'(score), 0);
        check_eq("rst_collect", int'(collect), 0);
        check_eq("rst_all_collected", int'(all_collected), 0);
        @(negedge pclk);
        rst_n = 1'b1;
        @(posedge pclk); #1;

        frame(0, 0, 0);
        pix(205, 105, 0, 1, 12'h123);
        pix(205, 105, 1, 0, 12'h123);
        pix(205, 105, 0, 0, 12'h123);
        pix(250, 105, 0, 0, 12'h456);
        pix(199, 105, 0, 0, 12'h789);
        pix(215, 115, 0, 0, 12'h789);
        pix(216, 105, 0, 0, 12'h0CD);
        pix(205, 116, 0, 0, 12'h0CD);
        pix(405, 105, 0, 0, 12'h111);

        frame(190, 90, 0);
        pix(205, 105, 0, 0, 12'h0AB);
        for (int k = 0; k < 3; k++) frame(190, 90, 0);
        frame(400, 100, 0);
        pix(425, 115, 0, 0, 12'h222);
        frame(600, 300, 0);
        frame(50, 400, 0);
        pix(605, 305, 0, 0, 12'h333);

        frame(600, 300, 3);
        frame(0, 0, 0);
        pix(205, 105, 0, 0, 12'h444);

        frame(190, 90, 0);
        for (int k = 0; k < 3; k++) frame(0, 0, 0);
        pix(205, 105, 0, 0, 12'h555);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
